// File: rtl/counter_rf_pkg.sv
// counter_rf_pkg
//   Shared constants for the counter register file: the software address
//   map, the width of the software data bus and the request decode type.
package counter_rf_pkg;

    localparam int DATA_W        = 64;
    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_OVF      = 1;
    localparam int ADDR_CNT_BASE = 2;

    // Classification of the software request seen on a clock edge.
    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_RD,
        REQ_WR,
        REQ_INV
    } req_kind_e;

endpackage

// File: rtl/counter_rf_if.sv
// counter_rf_if
//   Software access bus of the counter register file.
//   master: drives address / read_en / write_en / write_data,
//           receives read_data / access_complete / invalid_address.
//   slave : the register file side (reverse directions).
interface counter_rf_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0]             address;
    logic                              read_en;
    logic                              write_en;
    logic [counter_rf_pkg::DATA_W-1:0] write_data;
    logic [counter_rf_pkg::DATA_W-1:0] read_data;
    logic                              access_complete;
    logic                              invalid_address;

    modport master (
        output address, read_en, write_en, write_data,
        input  read_data, access_complete, invalid_address
    );

    modport slave (
        input  address, read_en, write_en, write_data,
        output read_data, access_complete, invalid_address
    );
endinterface

// File: rtl/counter_rf_cnt.sv
// counter_rf_cnt
//   One counter channel: enable-gated increment, wrap or saturate at the
//   maximum value, sticky overflow flag and a one-cycle pulse after a
//   software load.
//   Ports:
//     clk, res   clock, asynchronous active-high reset
//     en         channel enable (CTRL bit)
//     inc        hardware increment strobe
//     wr         software load of this channel this cycle
//     wr_data    value to load
//     ovf_clr    software clear of the overflow flag
//     value      counter register
//     overflow   sticky overflow flag
//     written    pulses the cycle after a software load
module counter_rf_cnt #(
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 en,
    input  logic                 inc,
    input  logic                 wr,
    input  logic [CNT_WIDTH-1:0] wr_data,
    input  logic                 ovf_clr,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 overflow,
    output logic                 written
);
    logic at_max_p0;
    logic step_p0;
    logic wrap_p0;

    // A software load takes priority: the increment of that cycle is lost.
    assign at_max_p0 = &value;
    assign step_p0   = inc & en & ~wr;
    assign wrap_p0   = step_p0 & at_max_p0;

    // ---- register stage ----
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            value    <= '0;
            overflow <= 1'b0;
            written  <= 1'b0;
        end else begin
            written  <= wr;
            // A new overflow beats a simultaneous software clear.
            overflow <= wrap_p0 | (overflow & ~ovf_clr);
            if (wr) begin
                value <= wr_data;
            end else if (step_p0) begin
                if (!at_max_p0) begin
                    value <= value + CNT_WIDTH'(1);
                end else if (SATURATE == 0) begin
                    value <= '0;
                end
            end
        end
    end
endmodule

// File: rtl/counter_rf.sv
// counter_rf
//   Software-accessible bank of NUM_CNT hardware event counters.
//   Address map (word addresses):
//     0            CTRL  per-channel enables, read/write
//     1            OVF   sticky overflow flags, write 1 to clear
//     2..NUM_CNT+1 counter k at 2+k
//   Every request completes one cycle after it is sampled; rejected
//   requests (unmapped address, or read and write together) change no
//   state and read back 0.
//   Ports:
//     clk, res      clock, asynchronous active-high reset
//     bus           software access bus (slave side)
//     cnt_inc       per-channel increment strobes
//     cnt_value     packed counter values, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
//     cnt_overflow  sticky overflow flags
//     cnt_written   per-channel pulse after a software write
module counter_rf
    import counter_rf_pkg::*;
#(
    parameter int NUM_CNT    = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int SATURATE   = 0
) (
    input  logic                           clk,
    input  logic                           res,
    counter_rf_if.slave                    bus,
    input  logic [NUM_CNT-1:0]             cnt_inc,
    output logic [NUM_CNT*CNT_WIDTH-1:0]   cnt_value,
    output logic [NUM_CNT-1:0]             cnt_overflow,
    output logic [NUM_CNT-1:0]             cnt_written
);
    localparam logic [ADDR_WIDTH:0] ADDR_END = (ADDR_WIDTH+1)'(NUM_CNT + ADDR_CNT_BASE);

    req_kind_e            kind_p0;
    logic                 in_map_p0;
    logic                 ctrl_wr_p0;
    logic                 ovf_wr_p0;
    logic [NUM_CNT-1:0]   ovf_clr_p0;
    logic [NUM_CNT-1:0]   cnt_wr_p0;
    logic [DATA_W-1:0]    rd_mux_p0;

    logic [NUM_CNT-1:0]   ctrl;
    logic [DATA_W-1:0]    read_data_p1;
    logic                 access_complete_p1;
    logic                 invalid_address_p1;

    // ---- request decode stage ----
    assign in_map_p0 = {1'b0, bus.address} < ADDR_END;

    always_comb begin
        kind_p0 = REQ_IDLE;
        if (bus.read_en && bus.write_en) begin
            kind_p0 = REQ_INV;
        end else if (bus.read_en || bus.write_en) begin
            if (!in_map_p0)       kind_p0 = REQ_INV;
            else if (bus.read_en) kind_p0 = REQ_RD;
            else                  kind_p0 = REQ_WR;
        end
    end

    assign ctrl_wr_p0 = (kind_p0 == REQ_WR) && (bus.address == ADDR_WIDTH'(ADDR_CTRL));
    assign ovf_wr_p0  = (kind_p0 == REQ_WR) && (bus.address == ADDR_WIDTH'(ADDR_OVF));
    assign ovf_clr_p0 = ovf_wr_p0 ? bus.write_data[NUM_CNT-1:0] : '0;

    // Read mux sees the register values before this edge's updates, so a
    // counter read returns the count prior to a coincident increment.
    always_comb begin
        rd_mux_p0 = '0;
        if (bus.address == ADDR_WIDTH'(ADDR_CTRL)) begin
            rd_mux_p0 = DATA_W'(ctrl);
        end else if (bus.address == ADDR_WIDTH'(ADDR_OVF)) begin
            rd_mux_p0 = DATA_W'(cnt_overflow);
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (bus.address == ADDR_WIDTH'(ADDR_CNT_BASE + k)) begin
                    rd_mux_p0 = DATA_W'(cnt_value[k*CNT_WIDTH +: CNT_WIDTH]);
                end
            end
        end
    end

    // ---- response / control register stage ----
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ctrl               <= '0;
            read_data_p1       <= '0;
            access_complete_p1 <= 1'b0;
            invalid_address_p1 <= 1'b0;
        end else begin
            access_complete_p1 <= (kind_p0 != REQ_IDLE);
            invalid_address_p1 <= (kind_p0 == REQ_INV);
            // read_data only moves on a read; rejected reads return 0.
            if (bus.read_en) begin
                read_data_p1 <= (kind_p0 == REQ_RD) ? rd_mux_p0 : '0;
            end
            if (ctrl_wr_p0) begin
                ctrl <= bus.write_data[NUM_CNT-1:0];
            end
        end
    end

    assign bus.read_data       = read_data_p1;
    assign bus.access_complete = access_complete_p1;
    assign bus.invalid_address = invalid_address_p1;

    // ---- per-channel counters ----
    for (genvar k = 0; k < NUM_CNT; k++) begin : g_ch
        assign cnt_wr_p0[k] = (kind_p0 == REQ_WR) &&
                              (bus.address == ADDR_WIDTH'(ADDR_CNT_BASE + k));

        counter_rf_cnt #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk      (clk),
            .res      (res),
            .en       (ctrl[k]),
            .inc      (cnt_inc[k]),
            .wr       (cnt_wr_p0[k]),
            .wr_data  (bus.write_data[CNT_WIDTH-1:0]),
            .ovf_clr  (ovf_clr_p0[k]),
            .value    (cnt_value[k*CNT_WIDTH +: CNT_WIDTH]),
            .overflow (cnt_overflow[k]),
            .written  (cnt_written[k])
        );
    end
endmodule

// File: tb/tb_counter_rf.sv
// tb_counter_rf
//   Drives a wrapping (SATURATE=0) and a saturating (SATURATE=1) instance
//   with identical stimulus. A behavioural model predicts register
//   contents; expected bus responses are queued at issue time and checked
//   by an independent monitor when access_complete appears.
module tb_counter_rf;

    typedef struct {
        bit          is_rd;
        bit          inv;
        logic [63:0] rd0;
        logic [63:0] rd1;
    } exp_t;

    logic        clk;
    logic        res;
    logic [3:0]  cnt_inc;
    logic [31:0] val0, val1;
    logic [3:0]  ovf0, ovf1;
    logic [3:0]  wrp0, wrp1;

    counter_rf_if #(.ADDR_WIDTH(3)) bus0 ();
    counter_rf_if #(.ADDR_WIDTH(3)) bus1 ();

    counter_rf #(.NUM_CNT(4), .CNT_WIDTH(8), .ADDR_WIDTH(3), .SATURATE(0)) d0 (
        .clk(clk), .res(res), .bus(bus0), .cnt_inc(cnt_inc),
        .cnt_value(val0), .cnt_overflow(ovf0), .cnt_written(wrp0)
    );

    counter_rf #(.NUM_CNT(4), .CNT_WIDTH(8), .ADDR_WIDTH(3), .SATURATE(1)) d1 (
        .clk(clk), .res(res), .bus(bus1), .cnt_inc(cnt_inc),
        .cnt_value(val1), .cnt_overflow(ovf1), .cnt_written(wrp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t       sb[$];
    logic [7:0] m_cnt [2][4];
    logic [3:0] m_ovf [2];
    logic [3:0] m_ctrl;
    logic [3:0] m_wr;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ovf[m] = '0;
            for (int k = 0; k < 4; k++) m_cnt[m][k] = '0;
        end
        m_ctrl = '0;
        m_wr   = '0;
    endfunction

    function automatic logic [31:0] exp_val(int m);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = m_cnt[m][k];
        return v;
    endfunction

    // Next-state rules of the register file, applied once per clock edge.
    function automatic void model_step(bit rd, bit wr, logic [2:0] a,
                                       logic [63:0] wd, logic [3:0] inc);
        exp_t       e;
        logic [3:0] wmask;
        logic [3:0] clr;
        logic [3:0] set;
        bit         valid;
        int         idx;
        valid = (rd != wr) && (a < 3'd6);
        idx   = int'(a) - 2;
        if (rd || wr) begin
            e.is_rd = rd;
            e.inv   = !valid;
            e.rd0   = '0;
            e.rd1   = '0;
            if (rd && valid) begin
                if (a == 3'd0) begin
                    e.rd0 = 64'(m_ctrl);
                    e.rd1 = 64'(m_ctrl);
                end else if (a == 3'd1) begin
                    e.rd0 = 64'(m_ovf[0]);
                    e.rd1 = 64'(m_ovf[1]);
                end else begin
                    e.rd0 = 64'(m_cnt[0][idx]);
                    e.rd1 = 64'(m_cnt[1][idx]);
                end
            end
            sb.push_back(e);
        end
        wmask = '0;
        clr   = '0;
        if (wr && valid) begin
            if (a == 3'd1)      clr = wd[3:0];
            else if (a >= 3'd2) wmask[idx] = 1'b1;
        end
        for (int m = 0; m < 2; m++) begin
            set = '0;
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) begin
                    m_cnt[m][k] = wd[7:0];
                end else if (inc[k] && m_ctrl[k]) begin
                    if (m_cnt[m][k] == 8'd255) begin
                        set[k] = 1'b1;
                        if (m == 0) m_cnt[m][k] = 8'd0;
                    end else begin
                        m_cnt[m][k] = m_cnt[m][k] + 8'd1;
                    end
                end
            end
            m_ovf[m] = (m_ovf[m] & ~clr) | set;
        end
        if (wr && valid && a == 3'd0) m_ctrl = wd[3:0];
        m_wr = wmask;
    endfunction

    task automatic set_bus(bit rd, bit wr, logic [2:0] a, logic [63:0] wd, logic [3:0] inc);
        bus0.read_en = rd;  bus1.read_en = rd;
        bus0.write_en = wr; bus1.write_en = wr;
        bus0.address = a;   bus1.address = a;
        bus0.write_data = wd; bus1.write_data = wd;
        cnt_inc = inc;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(bit rd, bit wr, logic [2:0] a, logic [63:0] wd, logic [3:0] inc);
        set_bus(rd, wr, a, wd, inc);
        model_step(rd, wr, a, wd, inc);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: samples 3 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (res) begin
                chk("rst_bus0", {bus0.access_complete, bus0.invalid_address, bus0.read_data[61:0]}, 64'd0);
                chk("rst_bus1", {bus1.access_complete, bus1.invalid_address, bus1.read_data[61:0]}, 64'd0);
                chk("rst_regs", {val0, ovf0, wrp0, val1[15:0]}, 64'd0);
                chk("rst_regs_hi", {bus0.read_data[63:62], bus1.read_data[63:62], val1[31:16], ovf1, wrp1}, 64'd0);
            end else begin
                chk("cnt_value_wrap", 64'(val0), 64'(exp_val(0)));
                chk("cnt_value_sat", 64'(val1), 64'(exp_val(1)));
                chk("cnt_overflow", {ovf0, ovf1}, {m_ovf[0], m_ovf[1]});
                chk("cnt_written", {wrp0, wrp1}, {m_wr, m_wr});
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("access_complete", {bus0.access_complete, bus1.access_complete}, 2'b11);
                    chk("invalid_address", {bus0.invalid_address, bus1.invalid_address}, {e.inv, e.inv});
                    if (e.is_rd) begin
                        chk("read_data_wrap", bus0.read_data, e.rd0);
                        chk("read_data_sat", bus1.read_data, e.rd1);
                    end
                end else begin
                    chk("idle_no_complete",
                        {bus0.access_complete, bus1.access_complete,
                         bus0.invalid_address, bus1.invalid_address}, 4'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          rd, wr;
        logic [2:0]  a;
        logic [63:0] wd;
        res = 1'b1;
        set_bus(1'b0, 1'b0, 3'd0, 64'd0, 4'd0);
        model_reset();
        repeat (3) @(negedge clk);
        res = 1'b0;

        // Reset contents read back as zero.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 3'(i), 64'd0, 4'd0);

        // Enable all, load 0xFE into channel 2, step it past the maximum.
        drive(1'b0, 1'b1, 3'd0, 64'hF, 4'd0);
        drive(1'b0, 1'b1, 3'd4, 64'hDEAD_BEEF_0000_00FE, 4'd0);
        drive(1'b0, 1'b0, 3'd0, 64'd0, 4'b0100);
        drive(1'b0, 1'b0, 3'd0, 64'd0, 4'b0100);
        chk("wrap_cnt2", 64'(val0[23:16]), 64'h00);
        chk("wrap_ovf2", 64'(ovf0[2]), 64'd1);
        chk("sat_cnt2", 64'(val1[23:16]), 64'hFF);
        chk("sat_ovf2", 64'(ovf1[2]), 64'd1);

        // Clear overflow bit 2.
        drive(1'b0, 1'b1, 3'd1, 64'h4, 4'd0);
        chk("ovf_cleared", {ovf0, ovf1}, 8'h00);

        // Load beats a coincident increment; disabled channel does not count.
        drive(1'b0, 1'b1, 3'd2, 64'h10, 4'b0001);
        chk("load_wins_wrap", 64'(val0[7:0]), 64'h10);
        chk("load_wins_sat", 64'(val1[7:0]), 64'h10);
        drive(1'b0, 1'b1, 3'd0, 64'hD, 4'd0);
        drive(1'b0, 1'b0, 3'd0, 64'd0, 4'b0010);
        chk("disabled_ch1", {val0[15:8], val1[15:8]}, 16'h0000);

        // Rejected requests.
        drive(1'b1, 1'b0, 3'd6, 64'd0, 4'd0);
        drive(1'b0, 1'b1, 3'd7, 64'hFFFF, 4'd0);
        drive(1'b1, 1'b1, 3'd4, 64'h55, 4'd0);
        drive(1'b1, 1'b1, 3'd0, 64'h0, 4'd0);
        drive(1'b1, 1'b0, 3'd0, 64'd0, 4'd0);
        drive(1'b1, 1'b0, 3'd4, 64'd0, 4'd0);
        chk("rejected_kept_wrap", 64'(val0[23:16]), 64'h00);
        chk("rejected_kept_sat", 64'(val1[23:16]), 64'hFF);

        // Counter read coincident with an increment of the same channel.
        drive(1'b0, 1'b1, 3'd0, 64'hF, 4'd0);
        drive(1'b1, 1'b0, 3'd3, 64'd0, 4'b1111);

        // Randomized traffic, biased towards counter values near the top.
        for (int i = 0; i < 400; i++) begin
            a  = 3'($urandom_range(0, 7));
            rd = 1'b0;
            wr = 1'b0;
            case ($urandom_range(0, 7))
                0, 1:    rd = 1'b1;
                2, 3, 4: wr = 1'b1;
                5:       begin rd = 1'b1; wr = ($urandom_range(0, 3) == 0); end
                default: ;
            endcase
            wd = {$urandom, $urandom};
            if (wr && a >= 3'd2 && $urandom_range(0, 1) == 1)
                wd[7:0] = 8'hFC + 8'($urandom_range(0, 3));
            if (wr && a == 3'd0 && $urandom_range(0, 1) == 1)
                wd[3:0] = 4'hF;
            drive(rd, wr, a, wd, 4'($urandom));
        end

        // Reset arriving while a write is completing.
        set_bus(1'b0, 1'b1, 3'd0, 64'h3, 4'd0);
        model_step(1'b0, 1'b1, 3'd0, 64'h3, 4'd0);
        @(posedge clk);
        #1;
        res = 1'b1;
        model_reset();
        sb.delete();
        set_bus(1'b0, 1'b0, 3'd0, 64'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid_complete", {bus0.access_complete, bus1.access_complete}, 2'b00);
        chk("rst_mid_values", {val0, val1}, 64'd0);
        res = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 4'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 3'(i), 64'd0, 4'd0);
        drive(1'b0, 1'b0, 3'd0, 64'd0, 4'd0);
        drive(1'b0, 1'b0, 3'd0, 64'd0, 4'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
